// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: data word, byte-enable mask and MEM-stage state.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS1,
    ACCESS2,
    COMPLETE
  } mem_access_state_t;

  localparam lc3b_mem_wmask WmaskWord = 2'b11;
  localparam lc3b_mem_wmask WmaskHigh = 2'b10;
  localparam lc3b_mem_wmask WmaskLow  = 2'b01;

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational byte lane: load byte extract/sign-extend, store byte replicate, wmask.
module mem_byte_lane
  import lc3b_types::*;
(
  input  logic          addr_lsb,
  input  logic          mem_byte,
  input  lc3b_word      rdata,
  input  lc3b_word      store_data,
  output lc3b_word      load_data,
  output lc3b_word      store_wdata,
  output lc3b_mem_wmask wmask
);

  logic [7:0] load_byte;

  always_comb begin
    load_byte = addr_lsb ? rdata[15:8] : rdata[7:0];
    if (mem_byte) begin
      load_data   = {{8{load_byte[7]}}, load_byte};
      store_wdata = {store_data[7:0], store_data[7:0]};
      wmask       = addr_lsb ? WmaskHigh : WmaskLow;
    end else begin
      load_data   = rdata;
      store_wdata = store_data;
      wmask       = WmaskWord;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// LC-3b MEM stage: data-memory handshake for LDR/STR/LDB/STB and two-access LDI/STI.
// Define MEM_ACCESS_STAGE_PERF_EN to add the saturating stall_cycles counter output.
module mem_access_stage
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_byte,
  input  logic              mem_indirect,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [15:0]       store_data_in,
  output logic              stall_out,
  output logic [15:0]       mem_out,
  output logic [ADDR_W-1:0] dmem_address,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [1:0]        dmem_wmask,
  output logic [15:0]       dmem_wdata,
  input  logic [15:0]       dmem_rdata,
  input  logic              dmem_resp
`ifdef MEM_ACCESS_STAGE_PERF_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(1);

  mem_access_state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  lc3b_word          mem_out_q, mem_out_d;

  logic          is_mem, is_byte;
  lc3b_word      lane_load, lane_wdata;
  lc3b_mem_wmask lane_wmask;

  assign is_mem  = valid_in & (mem_read | mem_write);
  // Indirect ops are always word accesses, so the byte flag is dropped for them.
  assign is_byte = mem_byte & ~mem_indirect;

  mem_byte_lane u_byte_lane (
    .addr_lsb    (address_in[0]),
    .mem_byte    (is_byte),
    .rdata       (dmem_rdata),
    .store_data  (store_data_in),
    .load_data   (lane_load),
    .store_wdata (lane_wdata),
    .wmask       (lane_wmask)
  );

  assign stall_out = is_mem & (state_q != COMPLETE);
  assign mem_out   = mem_out_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    mem_out_d    = mem_out_q;
    dmem_address = '0;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_wmask   = '0;
    dmem_wdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (is_mem) state_d = ACCESS1;
      end
      ACCESS1: begin
        dmem_address = address_in & AlignMask;
        if (mem_indirect) begin
          dmem_read  = 1'b1;
          dmem_wmask = WmaskWord;
          if (dmem_resp) begin
            ptr_d   = ADDR_W'(dmem_rdata);
            state_d = ACCESS2;
          end
        end else if (mem_read) begin
          dmem_read  = 1'b1;
          dmem_wmask = lane_wmask;
          if (dmem_resp) begin
            mem_out_d = lane_load;
            state_d   = COMPLETE;
          end
        end else begin
          dmem_write = 1'b1;
          dmem_wmask = lane_wmask;
          dmem_wdata = lane_wdata;
          if (dmem_resp) state_d = COMPLETE;
        end
      end
      ACCESS2: begin
        dmem_address = ptr_q & AlignMask;
        dmem_wmask   = WmaskWord;
        if (mem_read) begin
          dmem_read = 1'b1;
        end else begin
          dmem_write = 1'b1;
          dmem_wdata = store_data_in;
        end
        if (dmem_resp) begin
          if (mem_read) mem_out_d = dmem_rdata;
          state_d = COMPLETE;
        end
      end
      COMPLETE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      mem_out_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      mem_out_q <= mem_out_d;
    end
  end

`ifdef MEM_ACCESS_STAGE_PERF_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall_out && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized and directed bench for mem_access_stage against an access-list memory model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, mem_read, mem_write, mem_byte, mem_indirect;
  logic [15:0] address_in, store_data_in;
  logic        stall_out;
  logic [15:0] mem_out, dmem_address;
  logic        dmem_read, dmem_write;
  logic [1:0]  dmem_wmask;
  logic [15:0] dmem_wdata, dmem_rdata;
  logic        dmem_resp;
`ifdef MEM_ACCESS_STAGE_PERF_EN
  logic [15:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_byte      (mem_byte),
    .mem_indirect  (mem_indirect),
    .address_in    (address_in),
    .store_data_in (store_data_in),
    .stall_out     (stall_out),
    .mem_out       (mem_out),
    .dmem_address  (dmem_address),
    .dmem_read     (dmem_read),
    .dmem_write    (dmem_write),
    .dmem_wmask    (dmem_wmask),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_resp     (dmem_resp)
`ifdef MEM_ACCESS_STAGE_PERF_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
    logic        chk_mask;
  } acc_t;

  logic [15:0] mem [logic [15:0]];
  acc_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          stall_total = 0;
  logic [15:0] exp_out = 16'h0000;

  logic        r_rd, r_wr, r_byte, r_ind;
  logic [15:0] r_addr, r_sr;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'hA5C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_acc(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [1:0] wmask, input logic chk_mask);
    acc_t a;
    a.wr = wr; a.addr = addr; a.wdata = wdata; a.wmask = wmask; a.chk_mask = chk_mask;
    exp_q.push_back(a);
  endtask

  // Runs one memory op; fixed_lat < 0 picks a random 0..2 cycle response delay per access.
  task automatic run_op(input logic rd, input logic wr, input logic byt, input logic ind,
                        input logic [15:0] addr, input logic [15:0] sr, input int fixed_lat);
    logic [15:0] aw, pa, w;
    logic [7:0]  b;
    acc_t        a;
    int          lat, wait_n, stalls, exp_stall;
    exp_q.delete();
    aw = addr & 16'hFFFE;
    if (ind) begin
      pa = mem_rd(aw) & 16'hFFFE;
      push_acc(1'b0, aw, 16'h0, 2'b11, 1'b1);
      if (rd) begin
        push_acc(1'b0, pa, 16'h0, 2'b11, 1'b1);
        exp_out = mem_rd(pa);
      end else begin
        push_acc(1'b1, pa, sr, 2'b11, 1'b1);
      end
    end else if (rd) begin
      w = mem_rd(aw);
      push_acc(1'b0, aw, 16'h0, 2'b11, !byt);
      b = addr[0] ? w[15:8] : w[7:0];
      exp_out = byt ? {{8{b[7]}}, b} : w;
    end else if (byt) begin
      push_acc(1'b1, aw, {sr[7:0], sr[7:0]}, addr[0] ? 2'b10 : 2'b01, 1'b1);
    end else begin
      push_acc(1'b1, aw, sr, 2'b11, 1'b1);
    end

    @(negedge clk);
    valid_in = 1'b1; mem_read = rd; mem_write = wr; mem_byte = byt; mem_indirect = ind;
    address_in = addr; store_data_in = sr; dmem_resp = 1'b0;
    #1;
    check("stall_first_cycle", 32'(stall_out), 32'd1);
    check("idle_no_strobe", 32'({dmem_read, dmem_write}), 32'd0);
    stalls = 1;
    wait_n = 0;
    lat = (fixed_lat < 0) ? int'($urandom_range(0, 2)) : fixed_lat;
    exp_stall = 1 + lat + 1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      dmem_resp = 1'b0;
      #1;
      if (!stall_out) break;
      stalls++;
      if (exp_q.size() == 0) continue;
      a = exp_q[0];
      check("strobe_read", 32'(dmem_read), 32'(!a.wr));
      check("strobe_write", 32'(dmem_write), 32'(a.wr));
      check("dmem_address", 32'(dmem_address), 32'(a.addr));
      if (a.wr) check("dmem_wdata", 32'(dmem_wdata), 32'(a.wdata));
      if (a.chk_mask) check("dmem_wmask", 32'(dmem_wmask), 32'(a.wmask));
      if (wait_n == lat) begin
        dmem_resp = 1'b1;
        if (dmem_write) begin
          w = mem_rd(dmem_address);
          if (dmem_wmask[1]) w[15:8] = dmem_wdata[15:8];
          if (dmem_wmask[0]) w[7:0] = dmem_wdata[7:0];
          mem[dmem_address] = w;
        end else begin
          dmem_rdata = mem_rd(dmem_address);
        end
        void'(exp_q.pop_front());
        wait_n = 0;
        if (exp_q.size() > 0) begin
          lat = (fixed_lat < 0) ? int'($urandom_range(0, 2)) : fixed_lat;
          exp_stall += lat + 1;
        end
      end else begin
        wait_n++;
      end
    end
    check("complete_reached", 32'(stall_out), 32'd0);
    check("accesses_done", 32'(exp_q.size()), 32'd0);
    check("stall_count", 32'(stalls), 32'(exp_stall));
    check("mem_out", 32'(mem_out), 32'(exp_out));
    check("complete_no_strobe", 32'({dmem_read, dmem_write}), 32'd0);
    stall_total += stalls;
    // A stray response during COMPLETE must be ignored.
    if ($urandom_range(0, 3) == 0) begin
      dmem_resp = 1'b1;
      dmem_rdata = 16'($urandom);
    end
  endtask

  task automatic idle_cycle(input logic pass_op, input logic resp);
    @(negedge clk);
    valid_in = pass_op; mem_read = 1'b0; mem_write = 1'b0;
    dmem_resp = resp; dmem_rdata = 16'($urandom);
    #1;
    check("pass_stall", 32'(stall_out), 32'd0);
    check("pass_no_strobe", 32'({dmem_read, dmem_write}), 32'd0);
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    check("idle_after_resp", 32'({stall_out, dmem_read, dmem_write}), 32'd0);
    check("idle_mem_out", 32'(mem_out), 32'(exp_out));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_byte = 1'b0;
    mem_indirect = 1'b0; address_in = 16'h0; store_data_in = 16'h0;
    dmem_rdata = 16'h0; dmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 32'(stall_out), 32'd0);
    check("rst_mem_out", 32'(mem_out), 32'd0);
    check("rst_strobes", 32'({dmem_read, dmem_write}), 32'd0);
    check("rst_wmask", 32'(dmem_wmask), 32'd0);
    check("rst_address", 32'(dmem_address), 32'd0);
    check("rst_wdata", 32'(dmem_wdata), 32'd0);
    reset = 1'b0;

    mem[16'h3000] = 16'h1234;
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h3001, 16'h0, 0);
    check("ldr_value", 32'(mem_out), 32'h1234);
    mem[16'h4000] = 16'h80FF;
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h4001, 16'h0, 0);
    check("ldb_high", 32'(mem_out), 32'hFF80);
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h4000, 16'h0, 1);
    check("ldb_low", 32'(mem_out), 32'hFFFF);
    run_op(1'b0, 1'b1, 1'b1, 1'b0, 16'h5000, 16'hABCD, 2);
    check("stb_mem_low", 32'(mem_rd(16'h5000) & 16'h00FF), 32'h00CD);
    check("stb_keeps_mem_out", 32'(mem_out), 32'hFFFF);
    mem[16'h6000] = 16'h7000;
    mem[16'h7000] = 16'h0042;
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h6000, 16'h0, 0);
    check("ldi_value", 32'(mem_out), 32'h0042);
    mem[16'h6100] = 16'h8000;
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 16'h6100, 16'h55AA, 0);
    check("sti_mem", 32'(mem_rd(16'h8000)), 32'h55AA);
    idle_cycle(1'b1, 1'b1);

    // Reset while LDI waits in its second access.
    @(negedge clk);
    valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_byte = 1'b0; mem_indirect = 1'b1;
    address_in = 16'h6000; dmem_resp = 1'b0;
    @(negedge clk);
    dmem_resp = 1'b1; dmem_rdata = 16'h7000;
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    check("ldi2_read", 32'(dmem_read), 32'd1);
    check("ldi2_address", 32'(dmem_address), 32'h7000);
    reset = 1'b1; valid_in = 1'b0; mem_read = 1'b0; mem_indirect = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_read", 32'(dmem_read), 32'd0);
    check("mid_rst_stall", 32'(stall_out), 32'd0);
    check("mid_rst_mem_out", 32'(mem_out), 32'd0);
    check("mid_rst_address", 32'(dmem_address), 32'd0);
    dmem_resp = 1'b1; dmem_rdata = 16'h0042;
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    check("late_resp_mem_out", 32'(mem_out), 32'd0);
    check("late_resp_strobes", 32'({dmem_read, dmem_write, stall_out}), 32'd0);
    exp_out = 16'h0000;
    stall_total = 0;

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        r_rd   = 1'($urandom_range(0, 1));
        r_wr   = r_rd ? ($urandom_range(0, 3) == 0) : 1'b1;
        r_byte = 1'($urandom_range(0, 1));
        r_ind  = ($urandom_range(0, 2) == 0);
        r_addr = 16'h2000 | 16'($urandom_range(0, 15));
        r_sr   = 16'($urandom);
        run_op(r_rd, r_wr, r_byte, r_ind, r_addr, r_sr, -1);
      end
    end
    idle_cycle(1'b0, 1'b0);

`ifdef MEM_ACCESS_STAGE_PERF_EN
    check("perf_stall_cycles", 32'(stall_cycles), 32'(stall_total));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage LC-3b pipeline. Sits between EX_MEM and the MEM_WB register, and produces the mem_out word that MEM_WB latches.
- Runs the data-memory handshake for LDR/STR/LDB/STB and the two-access LDI/STI.
- Asserts stall_out while an access is outstanding, so upstream registers hold and the MEM_WB load is gated.

Parameters:
- ADDR_W, 16, address width; must equal the lc3b_word width.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  EX_MEM holds a live instruction
- mem_read  in  1  load-type op (LDR/LDB/LDI)
- mem_write  in  1  store-type op (STR/STB/STI)
- mem_byte  in  1  byte access (LDB/STB)
- mem_indirect  in  1  indirect access (LDI/STI)
- address_in  in  16  effective address (EX ALU result)
- store_data_in  in  16  SR value for stores
- stall_out  out  1  hold the pipeline; MEM_WB load must be 0 while high
- mem_out  out  16  load result to MEM_WB mem_out_in
- dmem_address  out  16  data memory address
- dmem_read  out  1  read strobe
- dmem_write  out  1  write strobe
- dmem_wmask  out  2  byte enables: [1] high byte, [0] low byte
- dmem_wdata  out  16  write data
- dmem_rdata  in  16  read data
- dmem_resp  in  1  single-cycle completion pulse from memory

Behaviour:
- Reset values: state IDLE; stall_out 0; mem_out 0; dmem_read 0; dmem_write 0; dmem_wmask 0; dmem_address 0; dmem_wdata 0.
- Reset asserted mid-access drops the strobes at that same edge. A late dmem_resp after reset is ignored.
- States: IDLE, ACCESS1, ACCESS2, COMPLETE.
- IDLE:
  - valid_in and (mem_read or mem_write) -> ACCESS1.
  - Otherwise stay in IDLE with stall_out 0 (pass-through; non-memory ops take zero extra cycles).
- ACCESS1:
  - Indirect op: word read of the pointer.
  - Direct load: read.
  - Direct store: write.
  - Strobes hold steady until dmem_resp.
  - On dmem_resp: indirect -> ACCESS2 and the pointer is latched; otherwise -> COMPLETE and mem_out is latched for loads.
- ACCESS2: read (LDI) or write (STI) at the latched pointer. On dmem_resp -> COMPLETE, latching mem_out for LDI.
- COMPLETE: stall_out 0 for exactly one cycle so the pipeline advances, then -> IDLE.
- stall_out = valid_in and (mem_read or mem_write) and state != COMPLETE. It is combinational and is high in the cycle the request is first seen.
- Word access:
  - dmem_address = {addr[15:1], 0}; dmem_wmask = 11.
  - An odd word address is silently aligned.
- LDB:
  - The byte is selected by addr[0] (1 = high byte).
  - mem_out = sign-extended byte.
- STB:
  - dmem_wdata = {sr[7:0], sr[7:0]}.
  - dmem_wmask = 10 if addr[0] else 01.
- mem_byte together with mem_indirect: indirect is honoured and byte is ignored.
- mem_read and mem_write both high: treated as a read; the write is ignored.
- Stores leave mem_out unchanged.
- The pointer read in ACCESS1 is always a full word.
- Latency with a 1-cycle memory:
  - Direct op: 3 cycles (ACCESS1 + resp, COMPLETE).
  - Indirect op: 4 cycles.
- dmem_resp seen in IDLE or COMPLETE is ignored.

Optional Feature:
- Macro: MEM_ACCESS_STAGE_PERF_EN.
- When defined:
  - Adds output stall_cycles (16 bits).
  - Increments once per clk with stall_out high; saturates at 0xFFFF.
  - Cleared by reset.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- The lc3b_types package gains:
  - lc3b_mem_wmask (2-bit logic).
  - mem_access_state_t enum {IDLE, ACCESS1, ACCESS2, COMPLETE}.
- Sub-module mem_byte_lane, combinational:
  - Load byte extraction with sign extension.
  - Store byte replication.
  - wmask generation from addr[0] and mem_byte.

Test Plan:
- LDR at 0x3001, rdata 0x1234, resp 1 cycle later:
  - dmem_address 0x3000, wmask 11.
  - stall high for 2 cycles, then mem_out 0x1234 with stall low in COMPLETE.
- LDB at 0x4001, rdata 0x80FF:
  - mem_out 0xFF80.
  - Same stimulus at 0x4000: mem_out 0xFFFF.
- STB at 0x5000, sr 0xABCD:
  - wdata 0xCDCD, wmask 01, dmem_write held until resp.
- LDI at 0x6000:
  - First read returns 0x7000; second read at 0x7000 returns 0x0042.
  - mem_out 0x0042; total stall 3 cycles.
- STI whose pointer read returns 0x8000, sr 0x55AA:
  - Write at 0x8000, wdata 0x55AA, wmask 11.
- Reset pulsed in ACCESS2 of LDI:
  - Next cycle dmem_read 0, stall_out 0, mem_out 0, state IDLE.
  - A resp arriving afterwards has no effect.
